// File: rtl/rarp_pkg.sv
// Shared constants and state encoding for the RARP receive parser.
package rarp_pkg;

    localparam logic [7:0]  EXP_HLEN    = 8'd6;
    localparam logic [7:0]  EXP_PLEN    = 8'd4;
    localparam logic [15:0] OP_RARP_REQ = 16'd3;
    localparam logic [15:0] OP_RARP_REP = 16'd4;
    localparam int          RARP_WORDS  = 7;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_CHECK,
        ST_HOLD
    } rarp_state_e;

    function automatic logic op_is_rarp(input logic [15:0] op);
        return (op == OP_RARP_REQ) || (op == OP_RARP_REP);
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + {{(W-1){1'b0}}, 1'b1};
        end
    end

endmodule

// File: rtl/rarp_rx_parser.sv
// Reassembles the 7-word RARP stream, validates the header and holds one
// decoded frame for the consumer until it is acknowledged.
//
// state   | meaning
// IDLE    | waiting for a word tagged rx_sof
// COLLECT | storing words 1..6; an rx_sof restarts the frame as truncated
// CHECK   | one cycle header validation, stream stalled
// HOLD    | decoded frame presented until frame_ack
module rarp_rx_parser
    import rarp_pkg::*;
#(
    parameter logic [15:0] EXP_HTYPE = 16'h0001,
    parameter logic [15:0] EXP_PTYPE = 16'h0800,
    parameter int          CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      rx_word,
    input  logic             rx_valid,
    input  logic             rx_sof,
    output logic             rx_ready,
    input  logic [47:0]      my_mac,
    output logic             frame_valid,
    input  logic             frame_ack,
    output logic [15:0]      oper,
    output logic [47:0]      sha,
    output logic [31:0]      spa,
    output logic [47:0]      tha,
    output logic [31:0]      tpa,
    output logic             for_me,
    output logic [CNT_W-1:0] acc_cnt,
    output logic [CNT_W-1:0] drop_cnt,
    output logic [CNT_W-1:0] trunc_cnt
);

    rarp_state_e                   state;
    logic [2:0]                    idx;
    logic [RARP_WORDS-1:0][31:0]   wbuf;

    logic        accept;
    logic        hdr_pass;
    logic [15:0] w_htype, w_ptype, w_oper;
    logic [7:0]  w_hlen, w_plen;
    logic [47:0] w_sha, w_tha;
    logic [31:0] w_spa;

    assign accept  = rx_valid && rx_ready;

    assign w_htype = wbuf[0][31:16];
    assign w_ptype = wbuf[0][15:0];
    assign w_hlen  = wbuf[1][31:24];
    assign w_plen  = wbuf[1][23:16];
    assign w_oper  = wbuf[1][15:0];
    assign w_sha   = {wbuf[2], wbuf[3][31:16]};
    assign w_spa   = {wbuf[3][15:0], wbuf[4][31:16]};
    assign w_tha   = {wbuf[4][15:0], wbuf[5]};

    assign hdr_pass = (w_htype == EXP_HTYPE) && (w_ptype == EXP_PTYPE) &&
                      (w_hlen == EXP_HLEN) && (w_plen == EXP_PLEN) &&
                      op_is_rarp(w_oper);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            idx         <= 3'd0;
            wbuf        <= '0;
            rx_ready    <= 1'b1;
            frame_valid <= 1'b0;
            for_me      <= 1'b0;
            oper        <= '0;
            sha         <= '0;
            spa         <= '0;
            tha         <= '0;
            tpa         <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept && rx_sof) begin
                        wbuf[0] <= rx_word;
                        idx     <= 3'd1;
                        state   <= ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (accept) begin
                        if (rx_sof) begin
                            wbuf[0] <= rx_word;
                            idx     <= 3'd1;
                        end else begin
                            wbuf[idx] <= rx_word;
                            idx       <= idx + 3'd1;
                            if (idx == 3'(RARP_WORDS - 1)) begin
                                state    <= ST_CHECK;
                                rx_ready <= 1'b0;
                            end
                        end
                    end
                end
                ST_CHECK: begin
                    if (hdr_pass) begin
                        oper        <= w_oper;
                        sha         <= w_sha;
                        spa         <= w_spa;
                        tha         <= w_tha;
                        tpa         <= wbuf[6];
                        for_me      <= (w_tha == my_mac);
                        frame_valid <= 1'b1;
                        state       <= ST_HOLD;
                    end else begin
                        rx_ready <= 1'b1;
                        state    <= ST_IDLE;
                    end
                end
                ST_HOLD: begin
                    if (frame_ack) begin
                        frame_valid <= 1'b0;
                        rx_ready    <= 1'b1;
                        state       <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Counters see the same decode the FSM acts on, so they step on the deciding edge.
    sat_counter #(.W(CNT_W)) u_acc_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   ((state == ST_CHECK) && hdr_pass),
        .count (acc_cnt)
    );

    sat_counter #(.W(CNT_W)) u_drop_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   ((state == ST_CHECK) && !hdr_pass),
        .count (drop_cnt)
    );

    sat_counter #(.W(CNT_W)) u_trunc_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   ((state == ST_COLLECT) && accept && rx_sof),
        .count (trunc_cnt)
    );

endmodule

// File: tb/tb_rarp_rx_parser.sv
// Bench for rarp_rx_parser: directed scenarios plus randomized frames against a
// frame-level model (whole frame as one 224-bit vector).
module tb_rarp_rx_parser;

    localparam logic [47:0] MAC_A = 48'h0011_2233_4455;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [31:0] rx_word = '0;
    logic        rx_valid = 1'b0;
    logic        rx_sof = 1'b0;
    logic        rx_ready;
    logic [47:0] my_mac = MAC_A;
    logic        frame_valid;
    logic        frame_ack = 1'b0;
    logic [15:0] oper;
    logic [47:0] sha, tha;
    logic [31:0] spa, tpa;
    logic        for_me;
    logic [15:0] acc_cnt, drop_cnt, trunc_cnt;

    logic        rx_ready_s, frame_valid_s, for_me_s;
    logic [15:0] oper_s;
    logic [47:0] sha_s, tha_s;
    logic [31:0] spa_s, tpa_s;
    logic [1:0]  acc_cnt_s, drop_cnt_s, trunc_cnt_s;

    int checks = 0;
    int errors = 0;
    int m_acc, m_drop, m_trunc;

    always #5 clk = ~clk;

    rarp_rx_parser dut (
        .clk(clk), .rst(rst), .rx_word(rx_word), .rx_valid(rx_valid), .rx_sof(rx_sof),
        .rx_ready(rx_ready), .my_mac(my_mac), .frame_valid(frame_valid), .frame_ack(frame_ack),
        .oper(oper), .sha(sha), .spa(spa), .tha(tha), .tpa(tpa), .for_me(for_me),
        .acc_cnt(acc_cnt), .drop_cnt(drop_cnt), .trunc_cnt(trunc_cnt)
    );

    rarp_rx_parser #(.CNT_W(2)) dut_sat (
        .clk(clk), .rst(rst), .rx_word(rx_word), .rx_valid(rx_valid), .rx_sof(rx_sof),
        .rx_ready(rx_ready_s), .my_mac(my_mac), .frame_valid(frame_valid_s), .frame_ack(frame_ack),
        .oper(oper_s), .sha(sha_s), .spa(spa_s), .tha(tha_s), .tpa(tpa_s), .for_me(for_me_s),
        .acc_cnt(acc_cnt_s), .drop_cnt(drop_cnt_s), .trunc_cnt(trunc_cnt_s)
    );

    // ---------------- frame-level model ----------------
    function automatic logic [223:0] make_frame(input logic [15:0] ht, pt, input logic [7:0] hl, pl,
                                                input logic [15:0] op, input logic [47:0] s_ha,
                                                input logic [31:0] s_pa, input logic [47:0] t_ha,
                                                input logic [31:0] t_pa);
        return {ht, pt, hl, pl, op, s_ha, s_pa, t_ha, t_pa};
    endfunction

    function automatic bit frame_ok(input logic [223:0] v);
        return v[223:208] == 16'h0001 && v[207:192] == 16'h0800 && v[191:184] == 8'd6 &&
               v[183:176] == 8'd4 && (v[175:160] == 16'd3 || v[175:160] == 16'd4);
    endfunction

    function automatic logic [223:0] rand_frame(input logic [47:0] t_ha);
        logic [15:0] ht = 16'h0001;
        logic [15:0] pt = 16'h0800;
        logic [7:0]  hl = 8'd6;
        logic [7:0]  pl = 8'd4;
        logic [15:0] op;
        op = ($urandom_range(0, 1) != 0) ? 16'd3 : 16'd4;
        case ($urandom_range(0, 9))
            0: ht ^= 16'($urandom_range(1, 65535));
            1: pt ^= 16'($urandom_range(1, 65535));
            2: hl ^= 8'($urandom_range(1, 255));
            3: pl ^= 8'($urandom_range(1, 255));
            4: op = 16'($urandom_range(5, 65535));
            5: op = 16'($urandom_range(0, 2));
            default: ;
        endcase
        return make_frame(ht, pt, hl, pl, op, {16'($urandom), $urandom}, $urandom,
                          t_ha, $urandom);
    endfunction

    function automatic logic [31:0] word_of(input logic [223:0] v, input int i);
        return v[223 - 32*i -: 32];
    endfunction

    // ---------------- drivers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1; rx_valid = 1'b0; rx_sof = 1'b0; frame_ack = 1'b0;
        tick(); tick();
        rst = 1'b0;
        m_acc = 0; m_drop = 0; m_trunc = 0;
    endtask

    task automatic send_word(input logic [31:0] w, input logic sof);
        int n = 0;
        rx_word = w; rx_sof = sof; rx_valid = 1'b1;
        while (rx_ready !== 1'b1 && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) begin
            errors++;
            $display("FAIL send_word_timeout: rx_ready=%b required 1", rx_ready);
        end
        tick();
        rx_valid = 1'b0; rx_sof = 1'b0;
    endtask

    task automatic send_words(input logic [223:0] v, input int first, input int last, input bit gaps);
        for (int i = first; i <= last; i++) begin
            send_word(word_of(v, i), i == 0);
            if (gaps && i < 6) repeat ($urandom_range(0, 2)) tick();
        end
    endtask

    task automatic ack_frame();
        frame_ack = 1'b1;
        tick();
        frame_ack = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (rx_ready !== 1'b1 || frame_valid !== 1'b0 || for_me !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rx_ready=%b frame_valid=%b for_me=%b required 1 0 0", rx_ready, frame_valid, for_me);
        end
        checks++;
        if ({oper, sha, spa, tha, tpa} !== 176'd0) begin
            errors++;
            $display("FAIL reset_fields: got %h required 0", {oper, sha, spa, tha, tpa});
        end
        checks++;
        if ({acc_cnt, drop_cnt, trunc_cnt} !== 48'd0) begin
            errors++;
            $display("FAIL reset_counters: got %0d %0d %0d required 0 0 0", acc_cnt, drop_cnt, trunc_cnt);
        end
    endtask

    task automatic test_good_request();
        logic [223:0] f;
        do_reset();
        my_mac = MAC_A;
        f = make_frame(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd3, 48'h00AA_BBCC_DDEE,
                       32'h0A00_0001, MAC_A, 32'h0A00_0002);
        send_words(f, 0, 6, 1'b0);
        checks++;
        if (frame_valid !== 1'b0 || rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL good_check_cycle: frame_valid=%b rx_ready=%b required 0 0", frame_valid, rx_ready);
        end
        tick();
        checks++;
        if (frame_valid !== 1'b1 || oper !== 16'd3 || for_me !== 1'b1 || acc_cnt !== 16'd1) begin
            errors++;
            $display("FAIL good_frame: valid=%b oper=%0d for_me=%b acc=%0d required 1 3 1 1", frame_valid, oper, for_me, acc_cnt);
        end
        checks++;
        if ({oper, sha, spa, tha, tpa} !== f[175:0]) begin
            errors++;
            $display("FAIL good_fields: got %h required %h", {oper, sha, spa, tha, tpa}, f[175:0]);
        end
        ack_frame();
        checks++;
        if (frame_valid !== 1'b0 || rx_ready !== 1'b1) begin
            errors++;
            $display("FAIL good_release: frame_valid=%b rx_ready=%b required 0 1", frame_valid, rx_ready);
        end
    endtask

    task automatic test_bad_header();
        logic [223:0] f;
        do_reset();
        f = make_frame(16'h0001, 16'h86DD, 8'd6, 8'd4, 16'd3, 48'h00AA_BBCC_DDEE,
                       32'h1, MAC_A, 32'h2);
        send_words(f, 0, 6, 1'b1);
        checks++;
        if (rx_ready !== 1'b0) begin
            errors++;
            $display("FAIL bad_check_cycle: rx_ready=%b required 0", rx_ready);
        end
        tick();
        checks++;
        if (rx_ready !== 1'b1 || frame_valid !== 1'b0 || drop_cnt !== 16'd1 || acc_cnt !== 16'd0) begin
            errors++;
            $display("FAIL bad_header: rx_ready=%b valid=%b drop=%0d acc=%0d required 1 0 1 0", rx_ready, frame_valid, drop_cnt, acc_cnt);
        end
        checks++;
        if ({oper, sha, spa, tha, tpa} !== 176'd0) begin
            errors++;
            $display("FAIL bad_fields_kept: got %h required 0", {oper, sha, spa, tha, tpa});
        end
    endtask

    task automatic test_truncation();
        logic [223:0] f1, f2;
        do_reset();
        f1 = make_frame(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd3, 48'h1111_1111_1111, 32'h1, MAC_A, 32'h1);
        f2 = make_frame(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd4, 48'h2222_3333_4444, 32'h5, 48'h9, 32'h6);
        send_words(f1, 0, 3, 1'b1);
        send_words(f2, 0, 6, 1'b1);
        tick();
        checks++;
        if (frame_valid !== 1'b1 || trunc_cnt !== 16'd1 || acc_cnt !== 16'd1 || for_me !== 1'b0) begin
            errors++;
            $display("FAIL trunc_counts: valid=%b trunc=%0d acc=%0d for_me=%b required 1 1 1 0", frame_valid, trunc_cnt, acc_cnt, for_me);
        end
        checks++;
        if ({oper, sha, spa, tha, tpa} !== f2[175:0]) begin
            errors++;
            $display("FAIL trunc_fields: got %h required %h", {oper, sha, spa, tha, tpa}, f2[175:0]);
        end
        ack_frame();
    endtask

    task automatic test_backpressure();
        logic [223:0] f1, f2;
        int bad = 0;
        do_reset();
        f1 = make_frame(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd3, 48'hA1, 32'hA2, MAC_A, 32'hA3);
        f2 = make_frame(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd4, 48'hB1, 32'hB2, 48'hB3, 32'hB4);
        send_words(f1, 0, 6, 1'b0);
        tick();
        for (int c = 0; c < 20; c++) begin
            rx_valid = 1'b1; rx_word = $urandom; rx_sof = 1'($urandom);
            tick();
            if (rx_ready !== 1'b0 || frame_valid !== 1'b1 || {oper, sha, spa, tha, tpa} !== f1[175:0]) bad++;
        end
        rx_valid = 1'b0; rx_sof = 1'b0;
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL backpressure_hold: %0d unstable cycles required 0", bad);
        end
        ack_frame();
        send_words(f2, 0, 6, 1'b1);
        tick();
        checks++;
        if (frame_valid !== 1'b1 || {oper, sha, spa, tha, tpa} !== f2[175:0] || acc_cnt !== 16'd2) begin
            errors++;
            $display("FAIL backpressure_next: valid=%b fields=%h acc=%0d required 1 %h 2", frame_valid, {oper, sha, spa, tha, tpa}, acc_cnt, f2[175:0]);
        end
        ack_frame();
    endtask

    task automatic test_async_reset();
        logic [223:0] good, bad;
        do_reset();
        good = make_frame(16'h0001, 16'h0800, 8'd6, 8'd4, 16'd3, 48'hC1, 32'hC2, MAC_A, 32'hC3);
        bad  = make_frame(16'h0002, 16'h0800, 8'd6, 8'd4, 16'd3, 48'hD1, 32'hD2, MAC_A, 32'hD3);
        send_words(bad, 0, 6, 1'b0);
        tick();
        send_words(good, 0, 3, 1'b0);
        rst = 1'b1;
        #1;
        checks++;
        if (drop_cnt !== 16'd0 || rx_ready !== 1'b1 || frame_valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_collect: drop=%0d rx_ready=%b valid=%b required 0 1 0", drop_cnt, rx_ready, frame_valid);
        end
        tick();
        rst = 1'b0;
        send_words(good, 0, 6, 1'b0);
        tick();
        checks++;
        if (frame_valid !== 1'b1 || acc_cnt !== 16'd1) begin
            errors++;
            $display("FAIL rst_collect_next: valid=%b acc=%0d required 1 1", frame_valid, acc_cnt);
        end
        rst = 1'b1;
        #1;
        checks++;
        if (frame_valid !== 1'b0 || for_me !== 1'b0 || acc_cnt !== 16'd0 || rx_ready !== 1'b1 ||
            {oper, sha, spa, tha, tpa} !== 176'd0) begin
            errors++;
            $display("FAIL rst_hold: valid=%b for_me=%b acc=%0d rx_ready=%b fields=%h required 0 0 0 1 0", frame_valid, for_me, acc_cnt, rx_ready, {oper, sha, spa, tha, tpa});
        end
        tick();
        rst = 1'b0;
        send_words(good, 0, 6, 1'b1);
        tick();
        checks++;
        if (frame_valid !== 1'b1 || acc_cnt !== 16'd1 || {oper, sha, spa, tha, tpa} !== good[175:0]) begin
            errors++;
            $display("FAIL rst_hold_next: valid=%b acc=%0d required 1 1", frame_valid, acc_cnt);
        end
        ack_frame();
    endtask

    task automatic test_saturation();
        logic [223:0] f;
        do_reset();
        for (int k = 1; k <= 5; k++) begin
            f = make_frame(16'h0001, 16'h0800, 8'd6, 8'd4, 16'($urandom_range(5, 99)), 48'h1, 32'h2, MAC_A, 32'h3);
            send_words(f, 0, 6, 1'b1);
            tick();
            checks++;
            if (drop_cnt_s !== 2'((k > 3) ? 3 : k) || drop_cnt !== 16'(k)) begin
                errors++;
                $display("FAIL saturation_%0d: drop2=%0d drop16=%0d required %0d %0d", k, drop_cnt_s, drop_cnt, (k > 3) ? 3 : k, k);
            end
        end
    endtask

    task automatic test_random();
        logic [223:0] f, pre;
        logic [175:0] exp_fields;
        int nerr = 0;
        do_reset();
        for (int n = 0; n < 40; n++) begin
            my_mac = ($urandom_range(0, 1) != 0) ? MAC_A : {16'($urandom), $urandom};
            f = rand_frame(($urandom_range(0, 2) != 0) ? my_mac : {16'($urandom), $urandom});
            if ($urandom_range(0, 3) == 0) begin
                send_word($urandom, 1'b0);
                ack_frame();
            end
            if ($urandom_range(0, 4) == 0) begin
                pre = rand_frame(MAC_A);
                send_words(pre, 0, $urandom_range(0, 5), 1'b1);
                m_trunc++;
            end
            send_words(f, 0, 6, 1'b1);
            if (rx_ready !== 1'b0 || frame_valid !== 1'b0) nerr++;
            tick();
            if (frame_ok(f)) begin
                m_acc++;
                exp_fields = f[175:0];
                checks++;
                if (frame_valid !== 1'b1 || {oper, sha, spa, tha, tpa} !== exp_fields ||
                    for_me !== (f[79:32] == my_mac) || acc_cnt !== 16'(m_acc)) begin
                    errors++;
                    $display("FAIL random_accept_%0d: valid=%b fields=%h for_me=%b acc=%0d required 1 %h %b %0d", n, frame_valid, {oper, sha, spa, tha, tpa}, for_me, acc_cnt, exp_fields, f[79:32] == my_mac, m_acc);
                end
                repeat ($urandom_range(0, 3)) tick();
                ack_frame();
            end else begin
                m_drop++;
                checks++;
                if (frame_valid !== 1'b0 || rx_ready !== 1'b1 || drop_cnt !== 16'(m_drop)) begin
                    errors++;
                    $display("FAIL random_drop_%0d: valid=%b rx_ready=%b drop=%0d required 0 1 %0d", n, frame_valid, rx_ready, drop_cnt, m_drop);
                end
            end
        end
        checks++;
        if (nerr !== 0 || trunc_cnt !== 16'(m_trunc)) begin
            errors++;
            $display("FAIL random_summary: check_cycle_errs=%0d trunc=%0d required 0 %0d", nerr, trunc_cnt, m_trunc);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_good_request();
        test_bad_header();
        test_truncation();
        test_backpressure();
        test_async_reset();
        test_saturation();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
